// File: rtl/processor_cpu_oci_dct_packer.sv
`default_nettype none
// ============================================================================
// Module   : processor_cpu_oci_dct_packer
// Brief    : Packs 2-bit OCI trace atoms LSB-first into a 30-bit DCT buffer and
//            hands full or flushed buffers downstream as valid/ready frames.
// Revision : 1.0 - initial release
// ============================================================================
module processor_cpu_oci_dct_packer #(
    parameter int ATOM_W = 2,
    parameter int DEPTH  = 15
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      atom_valid,
    input  logic [ATOM_W-1:0]         atom_data,
    output logic                      atom_ready,
    input  logic                      flush,
    output logic [ATOM_W*DEPTH-1:0]   dct_buffer,
    output logic [3:0]                dct_count,
    output logic                      frame_valid,
    output logic [ATOM_W*DEPTH-1:0]   frame_data,
    output logic [3:0]                frame_count,
    input  logic                      frame_ready,
    output logic                      trace_empty
);

    localparam int         c_BUF_W = ATOM_W * DEPTH;
    localparam logic [3:0] c_FULL  = 4'(DEPTH);

    logic [c_BUF_W-1:0] buf_q, buf_d;
    logic [3:0]         count_q, count_d;
    logic               flush_pend_q, flush_pend_d;
    logic               fvalid_q, fvalid_d;
    logic [c_BUF_W-1:0] fdata_q, fdata_d;
    logic [3:0]         fcount_q, fcount_d;

    logic               w_full;
    logic               w_empty;
    logic               w_slot_free;
    logic               w_xfer;
    logic               w_ready;
    logic               w_accept;
    logic [5:0]         w_shamt;
    logic [c_BUF_W-1:0] w_atom_ext;
    logic [c_BUF_W-1:0] w_atom_pos;

    assign w_full      = (count_q == c_FULL);
    assign w_empty     = (count_q == 4'd0);
    assign w_slot_free = !fvalid_q || frame_ready;
    assign w_xfer      = (w_full || (flush_pend_q && !w_empty)) && w_slot_free;
    assign w_ready     = !w_full || w_xfer;
    assign w_accept    = atom_valid && w_ready;
    assign w_shamt     = 6'(count_q) * 6'(ATOM_W);
    assign w_atom_ext  = c_BUF_W'(atom_data);
    // Unwritten positions are always zero, so OR-ing the new atom in is enough.
    assign w_atom_pos  = w_atom_ext << w_shamt;

    always_comb begin
        buf_d    = buf_q;
        count_d  = count_q;
        fvalid_d = fvalid_q;
        fdata_d  = fdata_q;
        fcount_d = fcount_q;
        if (w_xfer) begin
            fdata_d  = buf_q;
            fcount_d = count_q;
            fvalid_d = 1'b1;
            // An atom accepted alongside a transfer starts the next buffer.
            buf_d    = w_accept ? w_atom_ext : '0;
            count_d  = w_accept ? 4'd1 : 4'd0;
        end else begin
            if (frame_ready) begin
                fvalid_d = 1'b0;
            end
            if (w_accept) begin
                buf_d   = buf_q | w_atom_pos;
                count_d = count_q + 4'd1;
            end
        end
        flush_pend_d = flush || (flush_pend_q && !w_xfer && !(w_empty && !w_accept));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_q        <= '0;
            count_q      <= 4'd0;
            flush_pend_q <= 1'b0;
            fvalid_q     <= 1'b0;
            fdata_q      <= '0;
            fcount_q     <= 4'd0;
        end else begin
            buf_q        <= buf_d;
            count_q      <= count_d;
            flush_pend_q <= flush_pend_d;
            fvalid_q     <= fvalid_d;
            fdata_q      <= fdata_d;
            fcount_q     <= fcount_d;
        end
    end

    assign atom_ready  = w_ready;
    assign dct_buffer  = buf_q;
    assign dct_count   = count_q;
    assign frame_valid = fvalid_q;
    assign frame_data  = fdata_q;
    assign frame_count = fcount_q;
    assign trace_empty = w_empty && !flush_pend_q && !fvalid_q;

endmodule
`default_nettype wire
